led_fb_writer: RTL

LED_FB_WRITER -- requirements
Module: led_fb_writer

---
 rtl/led_fb_pkg.sv | 22 ++
 rtl/led_fb_bank.sv | 37 +++
 rtl/led_fb_writer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/led_fb_pkg.sv
// Shared constants, colour codes and FSM state type for the LED frame-buffer writer.
// No logic; combinational constants only.
// No flow control of its own.
package led_fb_pkg;

  localparam int NUM_LEDS    = 11;
  localparam int NUM_COLORS  = 3;
  localparam int VAL_W       = 8;
  localparam int NUM_ENTRIES = NUM_LEDS * NUM_COLORS;
  localparam int IDX_W       = 6;

  localparam logic [1:0] RED   = 2'd0;
  localparam logic [1:0] GREEN = 2'd1;
  localparam logic [1:0] BLUE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COPY    = 2'd2
  } fb_state_e;

endpackage

// File: rtl/led_fb_bank.sv
// One intensity bank: DEPTH x W registers, async clear, one write port, combinational reads.
// Write lands on the clock edge; reads are combinational (zero latency).
// No backpressure; out-of-range addresses are dropped on write and read back as 0.
module led_fb_bank import led_fb_pkg::*; #(
  parameter int DEPTH = NUM_ENTRIES,
  parameter int W     = VAL_W,
  parameter int AW    = IDX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  input  logic [AW-1:0] caddr,
  output logic [W-1:0]  cdata
);

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  logic [W-1:0] mem [DEPTH];

  // Storage: cleared asynchronously, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (waddr < LIMIT)) begin
      mem[waddr] <= wdata;
    end
  end

  // Driver-side read and copy-engine tap; the copy runs while the driver keeps reading.
  assign rdata = (raddr < LIMIT) ? mem[raddr] : '0;
  assign cdata = (caddr < LIMIT) ? mem[caddr] : '0;

endmodule

// File: rtl/led_fb_writer.sv
// Double-buffered LED intensity store: writes fill the back bank, a commit swaps on frame_sync.
// Read data is registered (1 cycle); a swap followed by a 33-cycle back-fill copy.
// wr_ready drops from commit until the copy finishes; writes stall in PENDING and COPY.
module led_fb_writer #(
  parameter int NUM_LEDS   = led_fb_pkg::NUM_LEDS,
  parameter int NUM_COLORS = led_fb_pkg::NUM_COLORS,
  parameter int VAL_W      = led_fb_pkg::VAL_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_led,
  input  logic [1:0]       wr_color,
  input  logic [VAL_W-1:0] wr_value,
  input  logic             wr_commit,
  output logic             wr_err,
  input  logic             frame_sync,
  input  logic [3:0]       rd_led,
  input  logic [1:0]       rd_color,
  output logic [VAL_W-1:0] rd_value,
  output logic             front_sel,
  output logic             swap_pending
);

  import led_fb_pkg::*;

  localparam int               BANK_DEPTH = NUM_LEDS * NUM_COLORS;
  localparam logic [3:0]       LED_LIM    = 4'(NUM_LEDS);
  localparam logic [1:0]       COL_LIM    = 2'(NUM_COLORS);
  localparam logic [IDX_W-1:0] COL_MUL    = IDX_W'(NUM_COLORS);
  localparam logic [IDX_W-1:0] COPY_LAST  = IDX_W'(BANK_DEPTH - 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  fb_state_e        state, state_nxt;
  logic [IDX_W-1:0] copy_idx;
  logic [IDX_W-1:0] wr_idx, rd_idx, bank_waddr;
  logic [VAL_W-1:0] bank_wdata;
  logic [VAL_W-1:0] rdata0, rdata1, cdata0, cdata1;
  logic             wr_fire, wr_ok, rd_ok, copying, swap_go, bank_wr;

  // Reset asserts immediately, releases two edges after rst_ rises.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Linear index led*3+color; 6 bits holds the worst case 15*3+3 = 48.
  assign wr_idx = IDX_W'(wr_led) * COL_MUL + IDX_W'(wr_color);
  assign rd_idx = IDX_W'(rd_led) * COL_MUL + IDX_W'(rd_color);
  assign wr_ok  = (wr_led < LED_LIM) && (wr_color < COL_LIM);
  assign rd_ok  = (rd_led < LED_LIM) && (rd_color < COL_LIM);

  assign wr_ready     = (state == IDLE);
  assign swap_pending = (state != IDLE);
  assign wr_fire      = wr_valid && wr_ready;
  assign copying      = (state == COPY);
  assign swap_go      = (state == PENDING) && frame_sync;

  // Next-state decode; frame_sync only matters while a swap is pending.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_fire && wr_commit) state_nxt = PENDING;
      PENDING: if (frame_sync)           state_nxt = COPY;
      COPY:    if (copy_idx == COPY_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, bank select, copy index, error pulse and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      copy_idx  <= '0;
      wr_err    <= 1'b0;
      rd_value  <= '0;
    end else begin
      state    <= state_nxt;
      wr_err   <= wr_fire && !wr_ok;
      rd_value <= rd_ok ? (front_sel ? rdata1 : rdata0) : '0;
      if (swap_go) begin
        front_sel <= !front_sel;
        copy_idx  <= '0;
      end else if (copying) begin
        copy_idx <= (copy_idx == COPY_LAST) ? '0 : copy_idx + 1'b1;
      end
    end
  end

  // Back bank takes host writes in IDLE and copy traffic in COPY; the two never overlap.
  assign bank_wr    = (wr_fire && wr_ok) || copying;
  assign bank_waddr = copying ? copy_idx : wr_idx;
  assign bank_wdata = copying ? (front_sel ? cdata1 : cdata0) : wr_value;

  led_fb_bank #(.DEPTH(BANK_DEPTH), .W(VAL_W), .AW(IDX_W)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_wr && front_sel),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (rd_idx),
    .rdata (rdata0),
    .caddr (copy_idx),
    .cdata (cdata0)
  );

  led_fb_bank #(.DEPTH(BANK_DEPTH), .W(VAL_W), .AW(IDX_W)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_wr && !front_sel),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (rd_idx),
    .rdata (rdata1),
    .caddr (copy_idx),
    .cdata (cdata1)
  );

endmodule
